// File: rtl/dvi_video_timing_ctrl.sv
// DVI frame scheduler: raster counters, pixel request/coordinate issue to an
// upstream source, and a 2-stage aligned RGB/hsync/vsync/de output pipeline.
module dvi_video_timing_ctrl #(
  parameter int unsigned H_ACT  = 1280,
  parameter int unsigned H_FP   = 110,
  parameter int unsigned H_SYNC = 40,
  parameter int unsigned H_BP   = 220,
  parameter int unsigned V_ACT  = 720,
  parameter int unsigned V_FP   = 5,
  parameter int unsigned V_SYNC = 5,
  parameter int unsigned V_BP   = 20,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input  logic        pclk,
  input  logic        rstin,
  input  logic        enable,
  output logic        pix_req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  input  logic [23:0] pix_data,
  output logic [23:0] video_din,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        video_de,
  output logic        frame_start,
  output logic        busy
);

  localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT_W  = 12'(H_ACT);
  localparam logic [11:0] H_HS_BEG = 12'(H_ACT + H_FP);
  localparam logic [11:0] H_HS_END = 12'(H_ACT + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
  localparam logic [11:0] V_ACT_W  = 12'(V_ACT);
  localparam logic [11:0] V_VS_BEG = 12'(V_ACT + V_FP);
  localparam logic [11:0] V_VS_END = 12'(V_ACT + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST   = 12'(V_TOT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP_PEND
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] h_cnt, v_cnt;
  logic        line_last, frame_last;
  logic        running, active, hs_region, vs_region;

  // stage-1 companions of pix_req, and stage-2 delayed copies
  logic        hs1, vs1, fs1;
  logic        de2, hs2, vs2, fs2;

  assign line_last  = (h_cnt == H_LAST);
  assign frame_last = line_last && (v_cnt == V_LAST);
  assign running    = (state != IDLE);
  assign active     = (h_cnt < H_ACT_W) && (v_cnt < V_ACT_W);
  assign hs_region  = (h_cnt >= H_HS_BEG) && (h_cnt < H_HS_END);
  assign vs_region  = (v_cnt >= V_VS_BEG) && (v_cnt < V_VS_END);

  always_ff @(posedge pclk) begin
    if (rstin) state <= IDLE;
    else       state <= state_nxt;
  end

  // Leaving STOP_PEND only at the final frame cycle keeps every frame whole.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (enable) state_nxt = RUN;
      RUN:       if (!enable) state_nxt = STOP_PEND;
      STOP_PEND: begin
        if (enable)          state_nxt = RUN;
        else if (frame_last) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rstin || !running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_last) begin
      h_cnt <= '0;
      v_cnt <= frame_last ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rstin) begin
      pix_req <= 1'b0;
      pix_x   <= '0;
      pix_y   <= '0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      fs1     <= 1'b0;
    end else begin
      pix_req <= active && running;
      if (active && running) begin
        pix_x <= h_cnt;
        pix_y <= v_cnt;
      end
      hs1 <= hs_region && running;
      vs1 <= vs_region && running;
      fs1 <= active && running && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge pclk) begin
    if (rstin) begin
      de2 <= 1'b0;
      hs2 <= 1'b0;
      vs2 <= 1'b0;
      fs2 <= 1'b0;
    end else begin
      de2 <= pix_req;
      hs2 <= hs1;
      vs2 <= vs1;
      fs2 <= fs1;
    end
  end

  // pix_data is valid during stage 2, so it is captured here alongside de2.
  always_ff @(posedge pclk) begin
    if (rstin) begin
      video_de    <= 1'b0;
      video_din   <= '0;
      video_hsync <= ~HS_POL;
      video_vsync <= ~VS_POL;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      video_de    <= de2;
      video_din   <= de2 ? pix_data : '0;
      video_hsync <= hs2 ? HS_POL : ~HS_POL;
      video_vsync <= vs2 ? VS_POL : ~VS_POL;
      frame_start <= fs2;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_dvi_video_timing_ctrl.sv
// Bench for dvi_video_timing_ctrl in small raster mode, one active-high and one
// active-low sync instance, checked against a frame-position reference model.
module tb_dvi_video_timing_ctrl;

  localparam int H_ACT = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACT = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        pclk, rstin, enable;
  logic        pix_req, video_hsync, video_vsync, video_de, frame_start, busy;
  logic [11:0] pix_x, pix_y;
  logic [23:0] pix_data, video_din;
  logic        n_pix_req, n_hsync, n_vsync, n_de, n_fs, n_busy;
  logic [11:0] n_pix_x, n_pix_y;
  logic [23:0] n_pix_data, n_din;

  int n_checks = 0;
  int n_fail   = 0;

  dvi_video_timing_ctrl #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut_p (
    .pclk(pclk), .rstin(rstin), .enable(enable),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .video_din(video_din), .video_hsync(video_hsync), .video_vsync(video_vsync),
    .video_de(video_de), .frame_start(frame_start), .busy(busy)
  );

  dvi_video_timing_ctrl #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_n (
    .pclk(pclk), .rstin(rstin), .enable(enable),
    .pix_req(n_pix_req), .pix_x(n_pix_x), .pix_y(n_pix_y), .pix_data(n_pix_data),
    .video_din(n_din), .video_hsync(n_hsync), .video_vsync(n_vsync),
    .video_de(n_de), .frame_start(n_fs), .busy(n_busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Pixel source: returns its coordinate one cycle after the request.
  always @(posedge pclk) begin
    pix_data   <= {pix_y, pix_x};
    n_pix_data <= {n_pix_y, n_pix_x};
  end

  function automatic bit is_act(int p);
    if (p < 0) return 1'b0;
    return ((p % H_TOT) < H_ACT) && ((p / H_TOT) < V_ACT);
  endfunction

  function automatic bit is_hs(int p);
    if (p < 0) return 1'b0;
    return ((p % H_TOT) >= H_ACT + H_FP) && ((p % H_TOT) < H_ACT + H_FP + H_SYNC);
  endfunction

  function automatic bit is_vs(int p);
    if (p < 0) return 1'b0;
    return ((p / H_TOT) >= V_ACT + V_FP) && ((p / H_TOT) < V_ACT + V_FP + V_SYNC);
  endfunction

  // Reference model: m_run says whether a frame is in progress, m_pos is the
  // position within the frame; hd[k] holds that position k cycles ago (-1 = idle).
  int  hd[4];
  bit  m_run, m_stop;
  int  m_pos;
  int  mx, my;
  bit  mon_en;

  initial begin
    for (int i = 0; i < 4; i++) hd[i] = -1;
    m_run = 0; m_stop = 0; m_pos = 0; mx = 0; my = 0;
  end

  always @(posedge pclk) begin
    int  new_pos;
    bit  new_run, new_stop;
    if (rstin) begin
      for (int i = 0; i < 4; i++) hd[i] = -1;
      m_run = 0; m_stop = 0; m_pos = 0; mx = 0; my = 0;
    end else begin
      new_pos  = m_run ? (m_pos + 1) % FRAME : 0;
      new_run  = m_run;
      new_stop = m_stop;
      if (!m_run) begin
        new_run = enable;
        new_stop = 0;
      end else if (enable) begin
        new_stop = 0;
      end else if (m_stop && m_pos == FRAME - 1) begin
        new_run = 0;
        new_stop = 0;
      end else begin
        new_stop = 1;
      end
      m_run = new_run; m_stop = new_stop; m_pos = new_run ? new_pos : 0;
      hd[3] = hd[2]; hd[2] = hd[1]; hd[1] = hd[0];
      hd[0] = m_run ? m_pos : -1;
    end
  end

  always @(negedge pclk) begin
    logic [24:0] e_req, e_n_req;
    logic [27:0] e_out;
    logic [4:0]  e_n_out;
    int p3;
    if (is_act(hd[1])) begin
      mx = hd[1] % H_TOT;
      my = hd[1] / H_TOT;
    end
    if (mon_en) begin
      p3    = hd[3];
      e_req = {is_act(hd[1]), 12'(my), 12'(mx)};
      e_out = {is_act(p3), is_act(p3) ? {12'(p3 / H_TOT), 12'(p3 % H_TOT)} : 24'h0,
               is_hs(p3), is_vs(p3), (p3 == 0)};
      e_n_req = e_req;
      e_n_out = {is_act(p3), !is_hs(p3), !is_vs(p3), (p3 == 0), (hd[0] >= 0)};
      n_checks++;
      if ({pix_req, pix_y, pix_x} !== e_req) begin
        n_fail++;
        $display("FAIL mon_req t=%0t got %h exp %h", $time, {pix_req, pix_y, pix_x}, e_req);
      end
      n_checks++;
      if ({video_de, video_din, video_hsync, video_vsync, frame_start} !== e_out) begin
        n_fail++;
        $display("FAIL mon_out t=%0t got %h exp %h", $time,
                 {video_de, video_din, video_hsync, video_vsync, frame_start}, e_out);
      end
      n_checks++;
      if (busy !== (hd[0] >= 0)) begin
        n_fail++;
        $display("FAIL mon_busy t=%0t got %b exp %b", $time, busy, (hd[0] >= 0));
      end
      n_checks++;
      if ({n_pix_req, n_pix_y, n_pix_x} !== e_n_req) begin
        n_fail++;
        $display("FAIL mon_n_req t=%0t got %h exp %h", $time, {n_pix_req, n_pix_y, n_pix_x}, e_n_req);
      end
      n_checks++;
      if ({n_de, n_hsync, n_vsync, n_fs, n_busy} !== e_n_out || n_din !== e_out[26:3]) begin
        n_fail++;
        $display("FAIL mon_n_out t=%0t got %b/%h exp %b/%h", $time,
                 {n_de, n_hsync, n_vsync, n_fs, n_busy}, n_din, e_n_out, e_out[26:3]);
      end
    end
  end

  task automatic wait_fs(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge pclk);
      if (frame_start) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_frame_start got timeout exp pulse within 400 cycles");
    end
  endtask

  task automatic test_reset();
    rstin = 1; enable = 0;
    repeat (3) @(negedge pclk);
    mon_en = 1;
    n_checks++;
    if ({pix_req, video_de, video_hsync, video_vsync, frame_start, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_p_ctrl got %b exp 000000",
               {pix_req, video_de, video_hsync, video_vsync, frame_start, busy});
    end
    n_checks++;
    if ({n_hsync, n_vsync} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_n_sync got %b exp 11", {n_hsync, n_vsync});
    end
    n_checks++;
    if ({video_din, pix_x, pix_y} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h exp 0", {video_din, pix_x, pix_y});
    end
    rstin = 0;
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_frames();
    bit ok;
    int de_c = 0, hs_c = 0, nhs_c = 0, vs_c = 0, nvs_c = 0, fs_c = 0;
    int run = 0, vs_run = 0, hs_first = -1, hs_l0 = 0;
    logic prev_hs = 0;
    enable = 1;
    wait_fs(ok);
    for (int i = 0; i < FRAME; i++) begin
      if (video_de) de_c++;
      if (video_hsync) begin
        hs_c++;
        if (i < H_TOT) hs_l0++;
      end
      if (!n_hsync) nhs_c++;
      if (!n_vsync) nvs_c++;
      if (frame_start) fs_c++;
      if (video_vsync) begin
        vs_c++; run++;
        if (run > vs_run) vs_run = run;
      end else run = 0;
      if (video_hsync && !prev_hs && hs_first < 0) hs_first = i;
      prev_hs = video_hsync;
      @(negedge pclk);
    end
    n_checks++;
    if (de_c !== V_ACT * H_ACT) begin
      n_fail++; $display("FAIL frame_de_count got %0d exp %0d", de_c, V_ACT * H_ACT);
    end
    n_checks++;
    if (hs_c !== V_TOT * H_SYNC || hs_l0 !== H_SYNC) begin
      n_fail++; $display("FAIL frame_hsync got %0d/%0d exp %0d/%0d", hs_c, hs_l0, V_TOT * H_SYNC, H_SYNC);
    end
    n_checks++;
    if (hs_first !== H_ACT + H_FP) begin
      n_fail++; $display("FAIL hsync_offset got %0d exp %0d", hs_first, H_ACT + H_FP);
    end
    n_checks++;
    if (vs_c !== V_SYNC * H_TOT || vs_run !== V_SYNC * H_TOT) begin
      n_fail++; $display("FAIL frame_vsync got %0d/%0d exp %0d", vs_c, vs_run, V_SYNC * H_TOT);
    end
    n_checks++;
    if (fs_c !== 1) begin
      n_fail++; $display("FAIL frame_start_count got %0d exp 1", fs_c);
    end
    n_checks++;
    if (nhs_c !== V_TOT * H_SYNC || nvs_c !== V_SYNC * H_TOT) begin
      n_fail++; $display("FAIL low_pol_sync got %0d/%0d exp %0d/%0d", nhs_c, nvs_c, V_TOT * H_SYNC, V_SYNC * H_TOT);
    end
  endtask

  task automatic test_stop();
    bit ok;
    int de_c = 0, fs_c = 0, t_idle = -1, bad = 0;
    wait_fs(ok);
    for (int i = 0; i < 300; i++) begin
      if (i == 20) enable = 0;
      if (video_de) de_c++;
      if (frame_start) fs_c++;
      if (!busy && t_idle < 0) t_idle = i;
      if (t_idle >= 0 && i >= t_idle + 4) break;
      @(negedge pclk);
    end
    n_checks++;
    if (t_idle !== FRAME - 3) begin
      n_fail++; $display("FAIL stop_busy_fall got %0d exp %0d", t_idle, FRAME - 3);
    end
    n_checks++;
    if (de_c !== V_ACT * H_ACT || fs_c !== 1) begin
      n_fail++; $display("FAIL stop_full_frame got de=%0d fs=%0d exp de=%0d fs=1", de_c, fs_c, V_ACT * H_ACT);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (pix_req || video_de || video_hsync || video_vsync || video_din != 0 ||
          !n_hsync || !n_vsync || busy) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL stop_idle_rest got %0d active cycles exp 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int de_c = 0, fs_c = 0, fs2 = -1;
    enable = 1;
    wait_fs(ok);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 30) enable = 0;
      if (i == 35) enable = 1;
      if (video_de) de_c++;
      if (frame_start) begin
        fs_c++;
        if (i > 0 && fs2 < 0) fs2 = i;
      end
      @(negedge pclk);
    end
    n_checks++;
    if (de_c !== 2 * V_ACT * H_ACT || fs_c !== 2) begin
      n_fail++; $display("FAIL b2b_frames got de=%0d fs=%0d exp de=%0d fs=2", de_c, fs_c, 2 * V_ACT * H_ACT);
    end
    n_checks++;
    if (fs2 !== FRAME) begin
      n_fail++; $display("FAIL b2b_period got %0d exp %0d", fs2, FRAME);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    int lat = -1;
    wait_fs(ok);
    repeat (2) @(negedge pclk);
    n_checks++;
    if (video_de !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre_de got %b exp 1", video_de);
    end
    rstin = 1;
    @(negedge pclk);
    n_checks++;
    if ({video_de, pix_req, busy, video_hsync, video_vsync, n_hsync, n_vsync} !== 7'b0000011) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got %b exp 0000011",
               {video_de, pix_req, busy, video_hsync, video_vsync, n_hsync, n_vsync});
    end
    rstin = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge pclk);
      if (pix_req) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat !== 2 || pix_x !== 12'd0 || pix_y !== 12'd0) begin
      n_fail++; $display("FAIL rst_mid_restart got lat=%0d x=%0d y=%0d exp lat=2 x=0 y=0", lat, pix_x, pix_y);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge pclk);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      rstin = ($urandom_range(0, 799) == 0);
    end
    rstin = 0;
    repeat (4) @(negedge pclk);
  endtask

  initial begin
    mon_en = 0;
    rstin  = 1;
    enable = 0;
    test_reset();
    test_frames();
    test_stop();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dvi_video_timing_ctrl.md
Name: dvi_video_timing_ctrl

Overview:
- Frame scheduler for the DVI transmitter path.
- Generates horizontal/vertical timing and issues per-pixel requests with coordinates to an upstream pixel source (character/overlay renderer).
- Drives the transmitter's RGB888, hsync, vsync and de inputs with all signals mutually aligned.
- Start/stop under an enable that only takes effect on frame boundaries, so the TMDS encoders never see a truncated frame.

Parameters:
- H_ACT, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACT, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level (1 = active-high)

Ports:
- pclk  in  1  pixel clock
- rstin  in  1  reset, synchronous, active-high
- enable  in  1  request to run video; sampled every cycle
- pix_req  out  1  pixel request; source must return pix_data exactly 1 cycle later
- pix_x  out  12  column of requested pixel, valid with pix_req
- pix_y  out  12  row of requested pixel, valid with pix_req
- pix_data  in  24  RGB888 pixel from source, valid the cycle after pix_req
- video_din  out  24  RGB888 to transmitter
- video_hsync  out  1  hsync to transmitter
- video_vsync  out  1  vsync to transmitter
- video_de  out  1  data enable to transmitter
- frame_start  out  1  1-cycle pulse coincident with the first video_de of each frame
- busy  out  1  high in RUN or STOP_PEND

Behaviour:
- Clock and reset: one clock, pclk. Reset is synchronous, active-high on rstin; it overrides everything, including mid-frame.
- Reset values:
  - state = IDLE; h_cnt = v_cnt = 0.
  - pix_req = 0, pix_x = pix_y = 0.
  - video_din = 0, video_de = 0, frame_start = 0, busy = 0.
  - video_hsync = ~HS_POL, video_vsync = ~VS_POL.
- Totals: H_TOT = H_ACT + H_FP + H_SYNC + H_BP; V_TOT = V_ACT + V_FP + V_SYNC + V_BP.
- Counters:
  - h_cnt runs 0..H_TOT-1 and wraps to 0; v_cnt increments when h_cnt wraps.
  - v_cnt runs 0..V_TOT-1 and wraps to 0.
  - Both counters are held at 0 in IDLE.
- Regions, with h_cnt/v_cnt as 0-based counts:
  - active when h_cnt < H_ACT AND v_cnt < V_ACT.
  - hsync active when H_ACT+H_FP <= h_cnt < H_ACT+H_FP+H_SYNC.
  - vsync active when V_ACT+V_FP <= v_cnt < V_ACT+V_FP+V_SYNC (whole lines).
- State machine:
  - IDLE: enable=1 → RUN; counting starts at (0,0) on the next cycle.
  - RUN: enable=0 → STOP_PEND; counting continues.
  - STOP_PEND:
    - enable=1 → RUN (no frame disruption).
    - At the last cycle of the frame (h_cnt = H_TOT-1, v_cnt = V_TOT-1) → IDLE.
  - In IDLE all outputs hold their reset values; the generator is never cut mid-frame except by rstin.
- Pipeline, with the cycle that counters hold (h, v) as stage 0:
  - Stage 1 (registered): pix_req = active(h, v) and state != IDLE; pix_x = h; pix_y = v; sync levels computed.
  - Stage 2: sync/de delayed one more cycle. pix_data is valid at the end of this cycle.
  - Output registers load at the end of stage 2:
    - video_de = delayed pix_req.
    - video_din = pix_data if delayed pix_req, else 24'h0.
    - hsync/vsync at their delayed levels, polarity applied.
  - Result: video_de, video_din and the syncs appear exactly 2 cycles after the matching pix_req; hsync/vsync stay aligned to de.
- pix_x and pix_y hold their last value when pix_req = 0. Widths: 12 bits covers H_TOT and V_TOT up to 4095.
- frame_start = video_de rising on the first active pixel (pix_x = 0, pix_y = 0), delayed like de.
- busy reflects state registered (0 in IDLE).
- Return to IDLE: sync outputs drain the 2-stage pipeline and then rest at the inactive level. No partial line is ever emitted.

Test Plan:
- Small-mode params (H_ACT=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACT=4, V_FP=1, V_SYNC=2, V_BP=1; H_TOT=16, V_TOT=8); rstin then enable=1 held → per line:
  - 8 de cycles;
  - hsync high for 3 cycles, starting 10 cycles after de rises;
  - frame period 128 cycles;
  - vsync high for exactly 32 consecutive cycles;
  - frame_start once per frame.
- Source returns pix_data = {pix_y, pix_x} registered → video_din while de equals the expected coordinate of each pixel; video_din = 0 when de = 0. Checks the 2-cycle latency.
- Drop enable mid-line of frame 1 → frame 1 completes fully (32 de cycles total); busy falls after the last frame cycle; outputs rest at 0 / inactive sync; no further pix_req.
- Drop and re-raise enable within the same frame → no gap or restart; counters continue; two back-to-back complete frames.
- Assert rstin mid-active-line → next cycle video_de=0, pix_req=0, syncs inactive, busy=0. Re-enable → first pix_req is at (0,0).
- HS_POL=0, VS_POL=0 → idle syncs = 1; sync pulses are low for 3 cycles / 32 cycles; de timing unchanged.
